// File: rtl/regfile_write_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_write_decoder
//  Purpose  : Register-file write-row decoder. Turns a valid address request
//             into a registered one-hot row select, flags out-of-range
//             addresses, and can optionally sweep every row in ascending order.
//  Options  : DEC_SWEEP_EN - when defined, adds the IDLE/SWEEP state machine
//             and its row counter. When undefined, sweep_start is ignored,
//             busy is 0 and req_ready is 1.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_write_decoder #(
    parameter int ADDR_W  = 3,
    parameter int NUM_OUT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [ADDR_W-1:0]  addr,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               sweep_start,
    output logic [NUM_OUT-1:0] dout,
    output logic               dout_valid,
    output logic               busy,
    output logic               addr_err
);

    // One extra bit so that NUM_OUT == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]  c_num_out = (ADDR_W + 1)'(NUM_OUT);
    localparam logic [NUM_OUT-1:0] c_one   = NUM_OUT'(1);

    logic [NUM_OUT-1:0] dout_q,       dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic               addr_err_q,   addr_err_d;

    logic w_addr_in_range;
    logic w_accept;

    assign w_addr_in_range = ({1'b0, addr} < c_num_out);
    assign w_accept        = req_valid && req_ready;

`ifdef DEC_SWEEP_EN
    // Counter carries one spare bit so it can reach NUM_OUT without wrapping.
    localparam int c_cnt_w = $clog2(NUM_OUT) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(NUM_OUT - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q,   cnt_d;

    // A sweep request in IDLE outranks a plain decode request.
    assign req_ready = (state_q == IDLE) && !(sweep_start && en);
    assign busy      = (state_q == SWEEP);
`else
    // Sweep hardware is absent; the port stays so the interface is fixed.
    logic w_unused_sweep;
    assign w_unused_sweep = sweep_start;
    assign req_ready      = 1'b1;
    assign busy           = 1'b0;
`endif

    // Next-state: selects default to zero so every select lasts one cycle.
    always_comb begin
        dout_d       = '0;
        dout_valid_d = 1'b0;
        addr_err_d   = 1'b0;

        // Plain decode path; disabled requests are consumed silently.
        if (w_accept && en) begin
            if (w_addr_in_range) begin
                dout_d       = c_one << addr;
                dout_valid_d = 1'b1;
            end else begin
                addr_err_d   = 1'b1;
            end
        end

`ifdef DEC_SWEEP_EN
        state_d = state_q;
        cnt_d   = cnt_q;

        // Sweep path never overlaps an accepted request (req_ready is low).
        if (state_q == SWEEP) begin
            if (!en) begin
                state_d = IDLE;
            end else begin
                dout_d       = c_one << cnt_q;
                dout_valid_d = 1'b1;
                cnt_d        = cnt_q + c_cnt_one;
                if (cnt_q == c_cnt_last) begin
                    state_d = IDLE;
                end
            end
        end else if (sweep_start && en) begin
            dout_d       = c_one;
            dout_valid_d = 1'b1;
            cnt_d        = c_cnt_one;
            state_d      = SWEEP;
        end
`endif
    end

    // State and output registers; reset clears everything without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
`ifdef DEC_SWEEP_EN
            state_q      <= IDLE;
            cnt_q        <= '0;
`endif
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            addr_err_q   <= addr_err_d;
`ifdef DEC_SWEEP_EN
            state_q      <= state_d;
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign addr_err   = addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_write_decoder
//  Purpose  : Self-checking bench for regfile_write_decoder. Two instances:
//             default geometry (8 rows) and a 6-row one with a 3-bit address
//             so out-of-range addresses exist. A queue-based reference model
//             predicts every output. Honours DEC_SWEEP_EN like the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       sweep_start = 1'b0;
    logic       req_valid = 1'b0;
    logic [2:0] addr8 = 3'd0;
    logic [2:0] addr6 = 3'd0;

    logic       ready8, ready6, dv8, dv6, busy8, busy6, err8, err6;
    logic [7:0] dout8;
    logic [5:0] dout6;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: rows still to be emitted by an active sweep, plus
    // the outputs predicted for the cycle after the last clock edge.
    int         sq8[$];
    int         sq6[$];
    logic [7:0] e_dout8 = 8'd0;
    logic [5:0] e_dout6 = 6'd0;
    logic       e_dv8 = 1'b0, e_dv6 = 1'b0, e_err8 = 1'b0, e_err6 = 1'b0;

    always #5 clk = ~clk;

    regfile_write_decoder #(.ADDR_W(3), .NUM_OUT(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .addr(addr8),
        .req_valid(req_valid), .req_ready(ready8), .sweep_start(sweep_start),
        .dout(dout8), .dout_valid(dv8), .busy(busy8), .addr_err(err8)
    );

    regfile_write_decoder #(.ADDR_W(3), .NUM_OUT(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .en(en), .addr(addr6),
        .req_valid(req_valid), .req_ready(ready6), .sweep_start(sweep_start),
        .dout(dout6), .dout_valid(dv6), .busy(busy6), .addr_err(err6)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic ready_model(input int remaining);
`ifdef DEC_SWEEP_EN
        return (remaining == 0) && !(sweep_start && en);
`else
        return 1'b1;
`endif
    endfunction

    // Predict the outputs after the coming edge for instance k (0: 8 rows, 1: 6 rows).
    task automatic model_step(input int k);
        int         q[$];
        int         n;
        logic [2:0] a;
        logic [7:0] d;
        logic       v, e;
        if (k == 0) begin q = sq8; n = 8; a = addr8; end
        else        begin q = sq6; n = 6; a = addr6; end
        d = 8'd0; v = 1'b0; e = 1'b0;
        if (q.size() > 0) begin
            if (!en) q.delete();
            else begin
                d = 8'd1 << q.pop_front();
                v = 1'b1;
            end
        end
`ifdef DEC_SWEEP_EN
        else if (sweep_start && en) begin
            for (int i = 1; i < n; i++) q.push_back(i);
            d = 8'd1;
            v = 1'b1;
        end
`endif
        else if (req_valid && en) begin
            if (int'(a) < n) begin
                d = 8'd1 << a;
                v = 1'b1;
            end else begin
                e = 1'b1;
            end
        end
        if (k == 0) begin sq8 = q; e_dout8 = d;      e_dv8 = v; e_err8 = e; end
        else        begin sq6 = q; e_dout6 = d[5:0]; e_dv6 = v; e_err6 = e; end
    endtask

    task automatic check_outputs();
        check_eq("dout8",  32'(dout8), 32'(e_dout8));
        check_eq("dv8",    32'(dv8),   32'(e_dv8));
        check_eq("err8",   32'(err8),  32'(e_err8));
        check_eq("busy8",  32'(busy8), 32'(sq8.size() > 0));
        check_eq("dout6",  32'(dout6), 32'(e_dout6));
        check_eq("dv6",    32'(dv6),   32'(e_dv6));
        check_eq("err6",   32'(err6),  32'(e_err6));
        check_eq("busy6",  32'(busy6), 32'(sq6.size() > 0));
    endtask

    // One clock: check last prediction, drive new inputs, check ready, predict.
    task automatic cycle(input logic e_i, input logic s_i, input logic v_i,
                         input logic [2:0] a8, input logic [2:0] a6);
        @(negedge clk);
        check_outputs();
        en = e_i; sweep_start = s_i; req_valid = v_i; addr8 = a8; addr6 = a6;
        #1;
        check_eq("ready8", 32'(ready8), 32'(ready_model(sq8.size())));
        check_eq("ready6", 32'(ready6), 32'(ready_model(sq6.size())));
        if (rst_n) begin
            model_step(0);
            model_step(1);
        end
    endtask

    // Assert reset between edges and verify outputs clear with no clock edge.
    task automatic async_reset();
        @(negedge clk);
        check_outputs();
        en = 1'b0; sweep_start = 1'b0; req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_dout8", 32'(dout8), 32'd0);
        check_eq("arst_dv8",   32'(dv8),   32'd0);
        check_eq("arst_busy8", 32'(busy8), 32'd0);
        check_eq("arst_err8",  32'(err8),  32'd0);
        check_eq("arst_dout6", 32'(dout6), 32'd0);
        check_eq("arst_busy6", 32'(busy6), 32'd0);
        sq8.delete(); sq6.delete();
        e_dout8 = 8'd0; e_dv8 = 1'b0; e_err8 = 1'b0;
        e_dout6 = 6'd0; e_dv6 = 1'b0; e_err6 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_ready8", 32'(ready8), 32'd1);
    endtask

    initial begin
        // Reset state, before any clock edge.
        #1;
        check_outputs();
        check_eq("rst_ready8", 32'(ready8), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back requests on the first edges after reset release.
        cycle(1'b1, 1'b0, 1'b1, 3'd5, 3'd7);
        cycle(1'b1, 1'b0, 1'b1, 3'd2, 3'd3);
        check_eq("b2b_first_dout8",  32'(dout8), 32'h20);
        check_eq("oor_err6_pulse",   32'(err6),  32'd1);
        check_eq("oor_dout6_zero",   32'(dout6), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
        check_eq("b2b_second_dout8", 32'(dout8), 32'h04);
        check_eq("oor_err6_clear",   32'(err6),  32'd0);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
        check_eq("select_clears",    32'(dout8), 32'h00);

        // Disabled request: nothing selected, no error.
        cycle(1'b0, 1'b0, 1'b1, 3'd1, 3'd6);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 3'd0);

        // Sweep pulse colliding with a request, request held until accepted.
        cycle(1'b1, 1'b1, 1'b1, 3'd3, 3'd3);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b1, 3'd3, 3'd3);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 3'd0);

        // Sweep aborted by dropping en after three rows.
        cycle(1'b1, 1'b1, 1'b0, 3'd0, 3'd0);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
        cycle(1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 3'd0);

        // Sweep abandoned by asynchronous reset.
        cycle(1'b1, 1'b1, 1'b0, 3'd0, 3'd0);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
        async_reset();
        cycle(1'b1, 1'b0, 1'b1, 3'd4, 3'd4);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                async_reset();
            end else begin
                cycle(logic'($urandom_range(0, 7) != 0),
                      logic'($urandom_range(0, 9) == 0),
                      logic'($urandom_range(0, 1)),
                      3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)));
            end
        end
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
